// File: rtl/dar_cmd_bridge.sv
// rtl/dar_cmd_bridge.sv - byte-stream command front end for the dar register array
// Header bit7 selects write (header+data) or read (header -> one response byte).
module dar_cmd_bridge #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_w_en,
  output logic              reg_r_en,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WRITE,
    S_READ,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              rx_ready_q, rx_ready_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              w_en_q, w_en_d;
  logic              r_en_q, r_en_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              rx_fire;
  logic              tx_fire;

  assign rx_fire = rx_valid & rx_ready_q;
  assign tx_fire = tx_valid_q & tx_ready;
  // Counter saturates so a disabled timeout never wraps back into range.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    w_en_d     = 1'b0;
    r_en_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          addr_d = rx_data[ADDR_W-1:0];
          if (rx_data[DATA_W-1]) begin
            state_d = S_WDATA;
            cnt_d   = '0;
          end else begin
            state_d = S_READ;
            r_en_d  = 1'b1;
          end
        end
      end
      S_WDATA: begin
        if (rx_fire) begin
          wdata_d = rx_data;
          w_en_d  = 1'b1;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_inc;
          if ((TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT))) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      S_READ: begin
        tx_data_d  = reg_rdata;
        tx_valid_d = 1'b1;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
    // Handshake/status outputs are decoded from the next state so they stay registered.
    rx_ready_d = (state_d == S_IDLE) || (state_d == S_WDATA);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rx_ready_q <= 1'b1;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      w_en_q     <= 1'b0;
      r_en_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      w_en_q     <= w_en_d;
      r_en_q     <= r_en_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_w_en  = w_en_q;
  assign reg_r_en  = r_en_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
